key_bounce_gen: RTL

KEY_BOUNCE_GEN -- requirements
Module: key_bounce_gen

---
 rtl/key_bounce_gen_pkg.sv | 32 +++
 rtl/key_bounce_gen_if.sv | 26 ++
 rtl/key_bounce_gen_lfsr16.sv | 19 +
 rtl/key_bounce_gen.sv | 137 +++++++++++++
 4 files changed

// File: rtl/key_bounce_gen_pkg.sv
// Shared types, constants and parameter defaults for the key bounce emulator.
// Also holds the LFSR step and seed-sanitising helpers.
package key_bounce_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BOUNCE,
      ST_SETTLE
   } kb_state_e;

   // Taps for x^16 + x^14 + x^13 + x^11 + 1 (state bits 15, 13, 12, 10).
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam int unsigned GAP_W = 16;

   localparam int unsigned DEF_BOUNCE_CNT  = 3;
   localparam int unsigned DEF_GAP_MIN     = 4;
   localparam logic [15:0] DEF_GAP_MASK    = 16'h0003;
   localparam int unsigned DEF_SETTLE_CYC  = 20;
   localparam logic        DEF_RESET_LEVEL = 1'b1;
   localparam logic [15:0] DEF_LFSR_SEED   = 16'hACE1;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

   // An all-zero seed would lock the LFSR up, so it is replaced by 1.
   function automatic logic [15:0] seed_fix(input logic [15:0] s);
      return (s == '0) ? 16'h0001 : s;
   endfunction

endpackage

// File: rtl/key_bounce_gen_if.sv
// Key-level signals between the stimulus side (master) and the emulator (slave).
interface key_bounce_gen_if;

   logic Pin_in;
   logic Bounce_en;
   logic Pin_out;
   logic Busy;
   logic Done;

   modport master (
      output Pin_in,
      output Bounce_en,
      input  Pin_out,
      input  Busy,
      input  Done
   );

   modport slave (
      input  Pin_in,
      input  Bounce_en,
      output Pin_out,
      output Busy,
      output Done
   );

endinterface

// File: rtl/key_bounce_gen_lfsr16.sv
// 16-bit Fibonacci LFSR, free-running, with a synchronous load of a sanitised seed.
module lfsr16
   import key_bounce_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] seed,
   output logic [15:0] state
);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= seed_fix(seed);
      end else begin
         state <= lfsr_step(state);
      end
   end

endmodule

// File: rtl/key_bounce_gen.sv
// Emulates a bouncing mechanical key: each clean level change on Pin_in becomes
// a burst of randomly timed away-and-back transitions followed by a settle window.
module key_bounce_gen
   import key_bounce_pkg::*;
#(
   parameter int unsigned BOUNCE_CNT  = DEF_BOUNCE_CNT,
   parameter int unsigned GAP_MIN     = DEF_GAP_MIN,
   parameter logic [15:0] GAP_MASK    = DEF_GAP_MASK,
   parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
   parameter logic        RESET_LEVEL = DEF_RESET_LEVEL,
   parameter logic [15:0] LFSR_SEED   = DEF_LFSR_SEED
)
(
   input  logic             Sys_clk,
   input  logic             Sys_reset,
   key_bounce_gen_if.slave  kb
);

   localparam logic [GAP_W-1:0] GAP_BASE  = GAP_W'(GAP_MIN - 1);
   localparam logic [GAP_W-1:0] SETTLE_LD = GAP_W'(SETTLE_CYC - 1);
   localparam logic [4:0]       TOGGLES   = 5'(2 * BOUNCE_CNT);

   kb_state_e        state_q, state_d;
   logic             pin_in_r;
   logic             level_q, level_d;
   logic             pin_out_q, pin_out_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             tgt_q, tgt_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [4:0]       tog_q, tog_d;
   logic [15:0]      lfsr_q;
   logic [GAP_W-1:0] hold_ld;

   lfsr16 u_lfsr (
      .clk   (Sys_clk),
      .rst   (Sys_reset),
      .seed  (LFSR_SEED),
      .state (lfsr_q)
   );

   // Counter preload for a segment of H cycles, sampled at segment start.
   assign hold_ld = GAP_BASE + (lfsr_q & GAP_MASK);

   always_ff @(posedge Sys_clk) begin
      if (Sys_reset) begin
         state_q   <= ST_IDLE;
         pin_in_r  <= RESET_LEVEL;
         level_q   <= RESET_LEVEL;
         pin_out_q <= RESET_LEVEL;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         tgt_q     <= RESET_LEVEL;
         gap_q     <= '0;
         tog_q     <= '0;
      end else begin
         state_q   <= state_d;
         pin_in_r  <= kb.Pin_in;
         level_q   <= level_d;
         pin_out_q <= pin_out_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         tgt_q     <= tgt_d;
         gap_q     <= gap_d;
         tog_q     <= tog_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      level_d   = level_q;
      pin_out_d = pin_out_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      tgt_d     = tgt_q;
      gap_d     = gap_q;
      tog_d     = tog_q;

      unique case (state_q)
         ST_IDLE: begin
            if (!kb.Bounce_en) begin
               level_d   = pin_in_r;
               pin_out_d = pin_in_r;
            end else if (pin_in_r != level_q) begin
               tgt_d     = pin_in_r;
               pin_out_d = pin_in_r;
               busy_d    = 1'b1;
               if (TOGGLES != '0) begin
                  state_d = ST_BOUNCE;
                  gap_d   = hold_ld;
                  tog_d   = TOGGLES;
               end else begin
                  state_d = ST_SETTLE;
                  gap_d   = SETTLE_LD;
               end
            end
         end

         ST_BOUNCE: begin
            if (gap_q != '0) begin
               gap_d = gap_q - GAP_W'(1);
            end else begin
               // Odd remaining count means this toggle returns to tgt; the hold
               // after the final return is the settle window, not another segment.
               pin_out_d = tog_q[0] ? tgt_q : ~tgt_q;
               tog_d     = tog_q - 5'd1;
               if (tog_q == 5'd1) begin
                  state_d = ST_SETTLE;
                  gap_d   = SETTLE_LD;
               end else begin
                  gap_d   = hold_ld;
               end
            end
         end

         ST_SETTLE: begin
            if (gap_q != '0) begin
               gap_d = gap_q - GAP_W'(1);
            end else begin
               done_d  = 1'b1;
               level_d = tgt_q;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign kb.Pin_out = pin_out_q;
   assign kb.Busy    = busy_q;
   assign kb.Done    = done_q;

endmodule
